// File: rtl/cpu_parameters.sv
// Shared CPU-side definitions for the data-memory bridge: FSM states, timeout default
// and strobe-size classification.
package cpu_parameters;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } dmem_state_t;

  localparam int DMEM_TIMEOUT = 255;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_BAD  = 2'd3;

  // Strobe patterns at lane 0; legal strobes are these shifted by the byte offset.
  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

  function automatic logic [1:0] strobe_size(input logic [3:0] strb);
    case (strb)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return SZ_BYTE;
      4'b0011, 4'b0110, 4'b1100:          return SZ_HALF;
      STRB_WORD:                          return SZ_WORD;
      default:                            return SZ_BAD;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane handling: store data shift, strobe/offset legality on the request side,
// and lane extraction of read data on the response side.
module dmem_lane_align
  import cpu_parameters::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      cap_off_i,
  input  logic [3:0]      cap_strb_i,
  input  logic [XLEN-1:0] cap_data_i,
  output logic [XLEN-1:0] wdata_o,
  output logic            strb_ok_o,
  input  logic [1:0]      rsp_off_i,
  input  logic [3:0]      rsp_strb_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [15:0]     rdata_o
);

  logic [XLEN-1:0] rsh;

  assign wdata_o = cap_data_i << {cap_off_i, 3'b000};
  assign rsh     = rdata_i >> {rsp_off_i, 3'b000};

  // A strobe is legal only if its lowest lane matches the address offset and it stays in the word.
  always_comb begin
    strb_ok_o = 1'b0;
    case (strobe_size(cap_strb_i))
      SZ_BYTE: strb_ok_o = (cap_strb_i == (STRB_BYTE << cap_off_i));
      SZ_HALF: strb_ok_o = (cap_strb_i == (STRB_HALF << cap_off_i));
      SZ_WORD: strb_ok_o = (cap_off_i == 2'd0);
      default: strb_ok_o = 1'b0;
    endcase
  end

  always_comb begin
    rdata_o = 16'h0000;
    case (strobe_size(rsp_strb_i))
      SZ_BYTE: rdata_o = {{8{rsh[7]}}, rsh[7:0]};
      SZ_HALF: rdata_o = rsh[15:0];
      SZ_WORD: rdata_o = rdata_i[15:0];
      default: rdata_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge: one outstanding load/store from the mem stage onto a valid/ready word bus,
// with alignment, range and response-timeout checking and a one-cycle registered hit pulse.
module dmem_bridge
  import cpu_parameters::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] ADDR_BASE  = 32'h0000_0000,
  parameter logic [XLEN-1:0] ADDR_LIMIT = 32'h0000_FFFF,
  parameter int              TIMEOUT    = DMEM_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            r_v,
  input  logic            w_v,
  input  logic [XLEN-1:0] req_adr,
  input  logic [XLEN-1:0] req_data,
  input  logic [3:0]      req_strobe,
  output logic            busy,
  output logic            hit,
  output logic [15:0]     mem_res,
  output logic            mem_res_error,
  output logic            bus_req_v,
  input  logic            bus_req_ready,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_adr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_wstrb,
  input  logic            bus_rsp_v,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_rsp_err
);

  localparam int             CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TO_C = CW'(TIMEOUT);

  dmem_state_t     state_q, state_d;
  logic [1:0]      adr_lo_q, adr_lo_d;
  logic [3:0]      strb_q, strb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            hit_q, hit_d;
  logic            err_q, err_d;
  logic [15:0]     res_q, res_d;
  logic            req_v_q, req_v_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] badr_q, badr_d;
  logic [XLEN-1:0] wdat_q, wdat_d;
  logic [3:0]      wstrb_q, wstrb_d;

  logic [XLEN-1:0] wdata_sh;
  logic            strb_ok;
  logic [15:0]     rd_res;
  logic            in_range;
  logic            fault;
  logic [CW-1:0]   cnt_inc;

  dmem_lane_align #(.XLEN(XLEN)) u_align (
    .cap_off_i  (req_adr[1:0]),
    .cap_strb_i (req_strobe),
    .cap_data_i (req_data),
    .wdata_o    (wdata_sh),
    .strb_ok_o  (strb_ok),
    .rsp_off_i  (adr_lo_q),
    .rsp_strb_i (strb_q),
    .rdata_i    (bus_rdata),
    .rdata_o    (rd_res)
  );

  // Offset subtraction keeps the range check a single unsigned compare, even with BASE = 0.
  assign in_range = (req_adr - ADDR_BASE) <= (ADDR_LIMIT - ADDR_BASE);
  assign fault    = (r_v & w_v) | ~strb_ok | ~in_range;
  assign cnt_inc  = cnt_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    adr_lo_d = adr_lo_q;
    strb_d   = strb_q;
    cnt_d    = cnt_q;
    hit_d    = 1'b0;
    err_d    = err_q;
    res_d    = res_q;
    req_v_d  = req_v_q;
    we_d     = we_q;
    badr_d   = badr_q;
    wdat_d   = wdat_q;
    wstrb_d  = wstrb_q;
    case (state_q)
      IDLE: begin
        if (r_v | w_v) begin
          adr_lo_d = req_adr[1:0];
          strb_d   = req_strobe;
          if (fault) begin
            state_d = RESP;
            hit_d   = 1'b1;
            err_d   = 1'b1;
            res_d   = 16'h0000;
          end else begin
            state_d = REQ;
            req_v_d = 1'b1;
            we_d    = w_v;
            badr_d  = {req_adr[XLEN-1:2], 2'b00};
            wdat_d  = w_v ? wdata_sh : '0;
            wstrb_d = w_v ? req_strobe : 4'b0000;
          end
        end
      end
      REQ: begin
        if (bus_req_ready) begin
          req_v_d = 1'b0;
          cnt_d   = '0;
          if (bus_rsp_v) begin
            state_d = RESP;
            hit_d   = 1'b1;
            err_d   = bus_rsp_err;
            res_d   = we_q ? 16'h0000 : rd_res;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // A response in the last counted cycle still wins over the timeout.
        if (bus_rsp_v) begin
          state_d = RESP;
          hit_d   = 1'b1;
          err_d   = bus_rsp_err;
          res_d   = we_q ? 16'h0000 : rd_res;
        end else if (cnt_inc == TO_C) begin
          state_d = RESP;
          hit_d   = 1'b1;
          err_d   = 1'b1;
          res_d   = 16'h0000;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
        res_d   = 16'h0000;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      adr_lo_q <= 2'b00;
      strb_q   <= 4'b0000;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
      err_q    <= 1'b0;
      res_q    <= 16'h0000;
      req_v_q  <= 1'b0;
      we_q     <= 1'b0;
      badr_q   <= '0;
      wdat_q   <= '0;
      wstrb_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      adr_lo_q <= adr_lo_d;
      strb_q   <= strb_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      err_q    <= err_d;
      res_q    <= res_d;
      req_v_q  <= req_v_d;
      we_q     <= we_d;
      badr_q   <= badr_d;
      wdat_q   <= wdat_d;
      wstrb_q  <= wstrb_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign hit           = hit_q;
  assign mem_res       = res_q;
  assign mem_res_error = err_q;
  assign bus_req_v     = req_v_q;
  assign bus_we        = we_q;
  assign bus_adr       = badr_q;
  assign bus_wdata     = wdat_q;
  assign bus_wstrb     = wstrb_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: randomized loads/stores against a behavioural model,
// a scripted bus responder and an independent hit monitor.
module tb_dmem_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r_v = 1'b0, w_v = 1'b0;
  logic [31:0] req_adr = '0, req_data = '0;
  logic [3:0]  req_strobe = '0;
  logic        busy, hit, mem_res_error, bus_req_v, bus_we;
  logic [15:0] mem_res;
  logic [31:0] bus_adr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_req_ready = 1'b0, bus_rsp_v = 1'b0, bus_rsp_err = 1'b0;
  logic [31:0] bus_rdata = '0;

  dmem_bridge #(
    .XLEN(32), .ADDR_BASE(32'h0000_0000), .ADDR_LIMIT(32'h0000_FFFF), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .r_v(r_v), .w_v(w_v), .req_adr(req_adr), .req_data(req_data),
    .req_strobe(req_strobe), .busy(busy), .hit(hit), .mem_res(mem_res),
    .mem_res_error(mem_res_error), .bus_req_v(bus_req_v), .bus_req_ready(bus_req_ready),
    .bus_we(bus_we), .bus_adr(bus_adr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rsp_v(bus_rsp_v), .bus_rdata(bus_rdata), .bus_rsp_err(bus_rsp_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        err;
    logic [15:0] res;
  } exp_t;
  exp_t sbq[$];

  // Responder script for the transaction in flight
  int          cur_rdy = 0, cur_k = 0;
  bit          cur_same = 1'b0, cur_fault = 1'b0;
  logic [31:0] exp_badr = '0, exp_wdata = '0;
  logic [3:0]  exp_wstrb = '0;
  logic        exp_we = 1'b0;
  int          phase = 0, rcnt = 0, wcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int popc(input logic [3:0] s);
    int n = 0;
    for (int i = 0; i < 4; i++) if (s[i]) n++;
    return n;
  endfunction

  function automatic bit model_fault(input bit rd, input bit wr, input logic [31:0] adr,
                                     input logic [3:0] strb);
    int  off = int'(adr % 4);
    int  lo = -1;
    int  n = popc(strb);
    bit  legal;
    for (int i = 3; i >= 0; i--) if (strb[i]) lo = i;
    legal = (n == 1) || (n == 4) || (n == 2 && lo <= 2 && strb[lo+1]);
    return (rd && wr) || !legal || (lo != off) || (adr > 32'h0000_FFFF);
  endfunction

  function automatic logic [15:0] model_read(input logic [31:0] rdata, input int off,
                                             input logic [3:0] strb);
    logic [31:0] sh = rdata >> (8 * off);
    int          b;
    case (popc(strb))
      1: begin
        b = int'(sh & 32'hFF);
        if (b > 127) b = b - 256;
        return 16'(b);
      end
      2: return sh[15:0];
      default: return rdata[15:0];
    endcase
  endfunction

  // Bus responder: counts ready delay in REQ, response delay in WAIT; checks held bus fields.
  always @(negedge clk) begin
    bus_req_ready = 1'b0;
    bus_rsp_v     = 1'b0;
    if (phase == 0) begin
      if (bus_req_v) begin
        chk1("busy_in_req", busy, 1'b1);
        chk1("bus_on_fault", cur_fault, 1'b0);
        chk("bus_adr", bus_adr, exp_badr);
        chk1("bus_we", bus_we, exp_we);
        chk("bus_wstrb", 32'(bus_wstrb), 32'(exp_wstrb));
        if (exp_we) chk("bus_wdata", bus_wdata, exp_wdata);
        if (rcnt == cur_rdy) begin
          bus_req_ready = 1'b1;
          rcnt = 0;
          if (cur_same) bus_rsp_v = 1'b1;
          else begin
            phase = 1;
            wcnt  = 0;
          end
        end else rcnt++;
      end
    end else begin
      if (wcnt == cur_k) begin
        bus_rsp_v = 1'b1;
        phase = 0;
      end else wcnt++;
    end
  end

  // Monitor: every hit must match the oldest expectation, at the predicted cycle.
  always @(negedge clk) begin
    if (rst_n && hit) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_hit got=1 want=0 @%0t", $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("hit_cycle", 32'(cyc), 32'(e.cyc));
        chk1("mem_res_error", mem_res_error, e.err);
        if (!e.err) chk("mem_res", 32'(mem_res), 32'(e.res));
      end
    end
  end

  task automatic txn(input bit rd, input bit wr, input logic [31:0] adr, input logic [31:0] data,
                     input logic [3:0] strb, input logic [31:0] rdata, input bit berr,
                     input int rdy, input bit same, input int k, input bit noise);
    exp_t e;
    int   off = int'(adr % 4);
    bit   got = 1'b0;
    cur_fault = model_fault(rd, wr, adr, strb);
    cur_rdy   = rdy;
    cur_same  = same;
    cur_k     = k;
    exp_badr  = adr & 32'hFFFF_FFFC;
    exp_wdata = data << (8 * off);
    exp_wstrb = wr ? strb : 4'b0000;
    exp_we    = wr;
    @(negedge clk);
    bus_rdata   = rdata;
    bus_rsp_err = berr;
    r_v = rd; w_v = wr; req_adr = adr; req_data = data; req_strobe = strb;
    e.cyc = cyc + 1;
    if (cur_fault) begin
      e.err = 1'b1;
    end else if (same) begin
      e.cyc = e.cyc + rdy + 1;
      e.err = berr;
    end else if (k < TO) begin
      e.cyc = e.cyc + rdy + 2 + k;
      e.err = berr;
    end else begin
      e.cyc = e.cyc + rdy + 1 + TO;
      e.err = 1'b1;
    end
    e.res = wr ? 16'h0000 : model_read(rdata, off, strb);
    sbq.push_back(e);
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (hit) begin
        got = 1'b1;
        r_v = 1'b0;
      end else begin
        r_v = noise ? 1'($urandom % 2) : 1'b0;
        if (noise) req_adr = $urandom % 32'h10000;
      end
      w_v = 1'b0;
    end
    r_v = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL hit_wait got=none want=hit @%0t", $time);
      if (sbq.size() != 0) void'(sbq.pop_front());
    end
    @(negedge clk);
    chk1("idle_after_hit", busy, 1'b0);
    for (int i = 0; i < 40 && phase != 0; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk1({nm, "_busy"}, busy, 1'b0);
    chk1({nm, "_hit"}, hit, 1'b0);
    chk1({nm, "_err"}, mem_res_error, 1'b0);
    chk1({nm, "_reqv"}, bus_req_v, 1'b0);
    chk1({nm, "_we"}, bus_we, 1'b0);
    chk({nm, "_res"}, 32'(mem_res), 32'h0);
    chk({nm, "_adr"}, bus_adr, 32'h0);
    chk({nm, "_wdata"}, bus_wdata, 32'h0);
    chk({nm, "_wstrb"}, 32'(bus_wstrb), 32'h0);
  endtask

  task automatic reset_mid_wait();
    cur_fault = 1'b0; cur_rdy = 0; cur_same = 1'b0; cur_k = 20;
    exp_badr = 32'h40; exp_we = 1'b0; exp_wstrb = 4'b0000;
    @(negedge clk);
    r_v = 1'b1; req_adr = 32'h40; req_strobe = 4'b1111;
    @(negedge clk);
    r_v = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40 && phase != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk1("idle_after_rst", busy, 1'b0);
  endtask

  initial begin
    logic [3:0]  strb;
    logic [31:0] adr;
    int          off, sz, sel, k;
    bit          rd, wr;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    txn(1, 0, 32'h102, 32'h0, 4'b0100, 32'hAABBCCDD, 0, 0, 0, 0, 0);
    txn(0, 1, 32'h106, 32'h1234, 4'b1100, 32'h0, 0, 0, 0, 0, 0);
    txn(1, 0, 32'h101, 32'h0, 4'b1111, 32'h0, 0, 0, 0, 0, 0);
    txn(1, 0, 32'h200, 32'h0, 4'b1111, 32'h0, 0, 0, 0, TO + 2, 0);
    txn(1, 0, 32'h10, 32'h0, 4'b0011, 32'h8001_7FFE, 0, 5, 0, 1, 1);
    txn(1, 0, 32'hFFFF, 32'h0, 4'b1000, 32'h7F00_0000, 0, 0, 1, 0, 0);
    txn(1, 0, 32'h1_0000, 32'h0, 4'b1111, 32'h0, 0, 0, 0, 0, 0);
    txn(0, 1, 32'h22, 32'hBEEF, 4'b0011, 32'h0, 0, 1, 0, 2, 0);
    txn(1, 1, 32'h20, 32'h1, 4'b1111, 32'h0, 0, 0, 0, 0, 0);
    txn(1, 0, 32'h30, 32'h0, 4'b1111, 32'h1234_5678, 1, 0, 0, TO - 1, 0);

    for (int n = 0; n < 120; n++) begin
      sel = int'($urandom % 100);
      wr  = (sel < 40);
      rd  = !wr;
      if (sel >= 95) begin rd = 1'b1; wr = 1'b1; end
      sz = int'($urandom % 3);
      case (sz)
        0:       begin off = int'($urandom % 4); strb = 4'(4'b0001 << off); end
        1:       begin off = int'($urandom % 3); strb = 4'(4'b0011 << off); end
        default: begin off = 0; strb = 4'b1111; end
      endcase
      if ($urandom % 10 == 0) off = int'($urandom % 4);
      if ($urandom % 20 == 0) strb = 4'($urandom % 16);
      adr = (($urandom % 32'h10000) & 32'hFFFC) | 32'(off);
      if ($urandom % 20 == 0) adr = 32'h1_0000 + 32'($urandom % 64);
      k = ($urandom % 6 == 0) ? (TO - 1 + int'($urandom % 4)) : int'($urandom % 4);
      txn(rd, wr, adr, $urandom, strb, $urandom, ($urandom % 8) == 0,
          int'($urandom % 4), ($urandom % 5) == 0, k, 1'($urandom % 2));
    end

    reset_mid_wait();
    txn(1, 0, 32'h44, 32'h0, 4'b0010, 32'h0000_8000, 0, 0, 0, 0, 0);

    chk("sb_empty", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
